// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue path: ALU Operation encodings (as seen
// by the ALU, plus an ILLEGAL marker), RV32I major opcodes that the issue
// stage recognises, the Operation width, and the skid-buffer state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OPCODE_LENGTH = 4;

    // ALU Operation encodings
    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_XOR     = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_OR      = 4'b0011,
        ALU_SUB     = 4'b0100,
        ALU_ADDI    = 4'b0101,
        ALU_EQUAL   = 4'b1000,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] RV_OP_R      = 7'b0110011;
    localparam logic [6:0] RV_OP_I      = 7'b0010011;
    localparam logic [6:0] RV_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_OP_STORE  = 7'b0100011;
    localparam logic [6:0] RV_OP_BRANCH = 7'b1100011;

    // Occupancy of the head/skid buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

    // Register-register classes take SrcB from rs2; everything else
    // (including unknown opcodes) takes the immediate.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == RV_OP_R) || (opcode == RV_OP_BRANCH);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational decode of Opcode/Funct3/Funct7 into the ALU Operation code,
// the SrcB select and an illegal flag.
// Ports:
//   opcode_i     instr[6:0]
//   funct3_i     instr[14:12]
//   funct7_i     instr[31:25]
//   operation_o  ALU Operation code (ALU_ILLEGAL when unsupported)
//   use_imm_o    1: SrcB = immediate, 0: SrcB = rs2
//   illegal_o    instruction did not decode to a supported operation
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0]               opcode_i,
    input  logic [2:0]               funct3_i,
    input  logic [6:0]               funct7_i,
    output logic [OPCODE_LENGTH-1:0] operation_o,
    output logic                     use_imm_o,
    output logic                     illegal_o
);

    alu_op_e op_s;

    // Opcode class and function-field decode
    always_comb begin
        op_s = ALU_ILLEGAL;
        case (opcode_i)
            RV_OP_R: begin
                if (funct7_i == 7'b0000000) begin
                    case (funct3_i)
                        3'b000:  op_s = ALU_ADD;
                        3'b100:  op_s = ALU_XOR;
                        3'b110:  op_s = ALU_OR;
                        3'b111:  op_s = ALU_AND;
                        default: op_s = ALU_ILLEGAL;
                    endcase
                end else if ((funct7_i == 7'b0100000) && (funct3_i == 3'b000)) begin
                    op_s = ALU_SUB;
                end else begin
                    op_s = ALU_ILLEGAL;
                end
            end
            RV_OP_I: begin
                case (funct3_i)
                    3'b000:  op_s = ALU_ADDI;
                    3'b100:  op_s = ALU_XOR;
                    3'b110:  op_s = ALU_OR;
                    3'b111:  op_s = ALU_AND;
                    default: op_s = ALU_ILLEGAL;
                endcase
            end
            // Address generation: any width/sign variant is a plain add
            RV_OP_LOAD,
            RV_OP_STORE: op_s = ALU_ADD;
            RV_OP_BRANCH: begin
                if (funct3_i == 3'b000) begin
                    op_s = ALU_EQUAL;
                end else begin
                    op_s = ALU_ILLEGAL;
                end
            end
            default: op_s = ALU_ILLEGAL;
        endcase
    end

    assign operation_o = op_s;
    assign illegal_o   = (op_s == ALU_ILLEGAL);
    assign use_imm_o   = !uses_rs2(opcode_i);

endmodule

// File: rtl/alu_op_issue.sv
// -----------------------------------------------------------------------------
// alu_op_issue
// Issue stage feeding the ALU. Decodes the incoming instruction fields,
// selects SrcA/SrcB and the Operation code, and presents them from a
// registered head entry through a valid/ready handshake. A second (skid)
// entry absorbs one extra instruction while EX stalls so that in_ready can be
// a flop.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   flush             synchronous discard of all buffered entries
//   in_valid/in_ready decode-side handshake (in_ready registered)
//   Opcode/Funct3/Funct7, RD1, RD2, ImmG   decoded instruction and operands
//   out_valid/out_ready                    EX-side handshake
//   SrcA, SrcB, Operation, Illegal         registered ALU operands/opcode
// -----------------------------------------------------------------------------
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               Opcode,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    ImmG,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Illegal
);

    // Decoded view of the incoming instruction
    logic [OPCODE_LENGTH-1:0] dec_op_s;
    logic                     dec_use_imm_s;
    logic                     dec_ill_s;
    logic [DATA_WIDTH-1:0]    new_b_s;

    alu_op_decode u_decode (
        .opcode_i    (Opcode),
        .funct3_i    (Funct3),
        .funct7_i    (Funct7),
        .operation_o (dec_op_s),
        .use_imm_o   (dec_use_imm_s),
        .illegal_o   (dec_ill_s)
    );

    assign new_b_s = dec_use_imm_s ? ImmG : RD2;

    // Buffer state and handshake flops
    buf_state_e state_q,     state_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q,  in_ready_d;

    // Head entry (drives the outputs) and skid entry
    logic [DATA_WIDTH-1:0]    head_a_q,   head_a_d;
    logic [DATA_WIDTH-1:0]    head_b_q,   head_b_d;
    logic [OPCODE_LENGTH-1:0] head_op_q,  head_op_d;
    logic                     head_ill_q, head_ill_d;
    logic [DATA_WIDTH-1:0]    skid_a_q,   skid_a_d;
    logic [DATA_WIDTH-1:0]    skid_b_q,   skid_b_d;
    logic [OPCODE_LENGTH-1:0] skid_op_q,  skid_op_d;
    logic                     skid_ill_q, skid_ill_d;

    logic push_s;
    logic pop_s;

    assign push_s = in_valid && in_ready_q;
    assign pop_s  = out_valid_q && out_ready;

    // Next-state and entry movement for the head/skid buffer
    always_comb begin
        state_d    = state_q;
        head_a_d   = head_a_q;
        head_b_d   = head_b_q;
        head_op_d  = head_op_q;
        head_ill_d = head_ill_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
        skid_op_d  = skid_op_q;
        skid_ill_d = skid_ill_q;

        if (flush) begin
            // Concurrent input is dropped; a concurrent pop is already owned by EX
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push_s) begin
                        head_a_d   = RD1;
                        head_b_d   = new_b_s;
                        head_op_d  = dec_op_s;
                        head_ill_d = dec_ill_s;
                        state_d    = BUF_ONE;
                    end else begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_ONE: begin
                    if (push_s && pop_s) begin
                        // Old head leaves, new entry takes its place
                        head_a_d   = RD1;
                        head_b_d   = new_b_s;
                        head_op_d  = dec_op_s;
                        head_ill_d = dec_ill_s;
                        state_d    = BUF_ONE;
                    end else if (push_s) begin
                        // Head is stalled: park the new entry behind it
                        skid_a_d   = RD1;
                        skid_b_d   = new_b_s;
                        skid_op_d  = dec_op_s;
                        skid_ill_d = dec_ill_s;
                        state_d    = BUF_TWO;
                    end else if (pop_s) begin
                        state_d = BUF_EMPTY;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
                BUF_TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop_s) begin
                        head_a_d   = skid_a_q;
                        head_b_d   = skid_b_q;
                        head_op_d  = skid_op_q;
                        head_ill_d = skid_ill_q;
                        state_d    = BUF_ONE;
                    end else begin
                        state_d = BUF_TWO;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end

        // Handshake flops track the occupancy the buffer will have after this edge
        in_ready_d  = (state_d != BUF_TWO);
        out_valid_d = (state_d != BUF_EMPTY);
    end

    // State, handshake and entry registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            head_a_q    <= {DATA_WIDTH{1'b0}};
            head_b_q    <= {DATA_WIDTH{1'b0}};
            head_op_q   <= {OPCODE_LENGTH{1'b0}};
            head_ill_q  <= 1'b0;
            skid_a_q    <= {DATA_WIDTH{1'b0}};
            skid_b_q    <= {DATA_WIDTH{1'b0}};
            skid_op_q   <= {OPCODE_LENGTH{1'b0}};
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            head_a_q    <= head_a_d;
            head_b_q    <= head_b_d;
            head_op_q   <= head_op_d;
            head_ill_q  <= head_ill_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
            skid_op_q   <= skid_op_d;
            skid_ill_q  <= skid_ill_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign SrcA      = head_a_q;
    assign SrcB      = head_b_q;
    assign Operation = head_op_q;
    assign Illegal   = head_ill_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issue
// Self-checking bench for alu_op_issue. A behavioural model keeps the buffered
// instructions in a queue of at most two entries and decodes instructions
// straight from the RV32I rules; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_op_issue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ImmG;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        Illegal;

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Opcode    (Opcode),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .RD1       (RD1),
        .RD2       (RD2),
        .ImmG      (ImmG),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .Illegal   (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } ent_t;

    ent_t mq[$];
    bit   last_push;

    function automatic ent_t ref_entry(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                       logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
        ent_t e;
        e.a  = r1;
        e.b  = imm;
        e.op = 4'hF;
        if (opc == 7'h33) begin
            e.b = r2;
            if (f7 == 7'h00) begin
                if (f3 == 3'd0)      e.op = 4'h2;
                else if (f3 == 3'd4) e.op = 4'h1;
                else if (f3 == 3'd6) e.op = 4'h3;
                else if (f3 == 3'd7) e.op = 4'h0;
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.op = 4'h4;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd0)      e.op = 4'h5;
            else if (f3 == 3'd4) e.op = 4'h1;
            else if (f3 == 3'd6) e.op = 4'h3;
            else if (f3 == 3'd7) e.op = 4'h0;
        end else if (opc == 7'h03 || opc == 7'h23) begin
            e.op = 4'h2;
        end else if (opc == 7'h63) begin
            e.b = r2;
            if (f3 == 3'd0) e.op = 4'h8;
        end
        e.ill = (e.op == 4'hF);
        return e;
    endfunction

    // Expected {out_valid, in_ready, SrcA, SrcB, Operation, Illegal}
    function automatic logic [70:0] exp_vec();
        if (mq.size() == 0) return {1'b0, 1'b1, 69'd0};
        return {1'b1, (mq.size() < 2), mq[0].a, mq[0].b, mq[0].op, mq[0].ill};
    endfunction

    // Payload bits only matter while an entry is presented
    function automatic logic [70:0] exp_mask();
        if (mq.size() == 0) return {2'b11, 69'd0};
        return {71{1'b1}};
    endfunction

    function automatic logic [70:0] obs_vec();
        return {out_valid, in_ready, SrcA, SrcB, Operation, Illegal};
    endfunction

    // One clock: model transfers as seen at the edge, then move to the falling edge
    task automatic tick();
        bit   push;
        bit   pop;
        ent_t e;
        ent_t dummy;
        push = reset && in_valid && (mq.size() < 2);
        pop  = (mq.size() > 0) && out_ready;
        e    = ref_entry(Opcode, Funct3, Funct7, RD1, RD2, ImmG);
        @(posedge clk);
        last_push = 1'b0;
        if (!reset || flush) begin
            mq.delete();
        end else begin
            if (pop) dummy = mq.pop_front();
            if (push) begin
                mq.push_back(e);
                last_push = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                             logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
        Opcode = o; Funct3 = f3; Funct7 = f7; RD1 = r1; RD2 = r2; ImmG = imm;
    endtask

    task automatic set_rand_instr();
        logic [6:0] opcs [6];
        logic [6:0] f7s  [3];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
        opcs[5] = 7'($urandom);
        f7s  = '{7'h00, 7'h20, 7'h00};
        f7s[2] = 7'($urandom);
        set_instr(opcs[$urandom_range(0, 5)], 3'($urandom), f7s[$urandom_range(0, 2)],
                  $urandom, $urandom, $urandom);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (3) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        set_instr(7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();
        tests++;
        if ({out_valid, in_ready, Operation, SrcA, SrcB, Illegal} !== {1'b0, 1'b1, 4'h0, 64'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got v=%b r=%b op=%h a=%h b=%h ill=%b, exp v=0 r=1 op=0 a=0 b=0 ill=0",
                     out_valid, in_ready, Operation, SrcA, SrcB, Illegal);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        set_instr(7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0);
        tick();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, Operation, SrcA, SrcB} !== {1'b1, 4'b0100, 32'd10, 32'd3}) begin
            fails++;
            $display("FAIL first_sub: got v=%b op=%h a=%0d b=%0d, exp v=1 op=4 a=10 b=3",
                     out_valid, Operation, SrcA, SrcB);
        end
        drain();
    endtask

    task automatic test_decode_sweep();
        logic [6:0]  s_opc [10] = '{7'h13, 7'h03, 7'h63, 7'h63, 7'h73, 7'h33, 7'h13, 7'h23, 7'h33, 7'h33};
        logic [2:0]  s_f3  [10] = '{3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd4, 3'd6, 3'd2, 3'd4, 3'd7};
        logic [6:0]  s_f7  [10] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
        logic [31:0] s_imm [10] = '{32'hFFFFFFFF, 32'h10, 32'h8, 32'h8, 32'h9, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        logic [31:0] s_rd2 [10] = '{32'h7, 32'h1234, 32'h55, 32'h66, 32'h77, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        logic [3:0]  x_op  [10] = '{4'h5, 4'h2, 4'h8, 4'hF, 4'hF, 4'h1, 4'h3, 4'h2, 4'hF, 4'h0};
        logic        x_ill [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] x_b   [10] = '{32'hFFFFFFFF, 32'h10, 32'h55, 32'h66, 32'h9, 32'hA1, 32'h2, 32'h3, 32'hA4, 32'hA5};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_instr(s_opc[i], s_f3[i], s_f7[i], 32'd5 + 32'(i), s_rd2[i], s_imm[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tests++;
            if ({out_valid, SrcA, SrcB, Operation, Illegal} !== {1'b1, 32'd5 + 32'(i), x_b[i], x_op[i], x_ill[i]}) begin
                fails++;
                $display("FAIL decode_%0d: got v=%b a=%h b=%h op=%h ill=%b, exp v=1 a=%h b=%h op=%h ill=%b",
                         i, out_valid, SrcA, SrcB, Operation, Illegal, 32'd5 + 32'(i), x_b[i], x_op[i], x_ill[i]);
            end
            tick();
            tests++;
            if ((obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL decode_drain_%0d: got %h exp %h", i, obs_vec() & exp_mask(), exp_vec());
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] seen [$];
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_instr(7'h33, 3'd0, 7'h00, 32'hA0 + 32'(i), 32'h1, 32'h0);
            in_valid = 1'b1;
            tick();
            tests++;
            if ((obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL bp_fill_%0d: got %h exp %h", i, obs_vec() & exp_mask(), exp_vec());
            end
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready_low: got %b exp 0", in_ready);
        end
        set_instr(7'h13, 3'd4, 7'h00, 32'hA2, 32'h0, 32'hF0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ((obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL bp_stall_%0d: got %h exp %h", i, obs_vec() & exp_mask(), exp_vec());
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready) seen.push_back(SrcA);
            tick();
            if (last_push) in_valid = 1'b0;
            tests++;
            if ((obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL bp_release_%0d: got %h exp %h", i, obs_vec() & exp_mask(), exp_vec());
            end
        end
        tests++;
        if (seen.size() != 3 || seen[0] !== 32'hA0 || seen[1] !== 32'hA1 || seen[2] !== 32'hA2) begin
            fails++;
            $display("FAIL bp_order: got %0d transfers, exp A0,A1,A2 in order", seen.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        int outs = 0;
        int not_ready = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 8);
            set_rand_instr();
            tick();
            if (out_valid) outs++;
            if (!in_ready) not_ready++;
            tests++;
            if ((obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL stream_%0d: got %h exp %h", i, obs_vec() & exp_mask(), exp_vec());
            end
        end
        tests++;
        if (outs != 8 || not_ready != 0) begin
            fails++;
            $display("FAIL stream_count: got outs=%0d not_ready=%0d, exp outs=8 not_ready=0", outs, not_ready);
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            set_rand_instr();
            tick();
        end
        flush = 1'b1;
        set_rand_instr();
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL flush_state: got v=%b r=%b, exp v=0 r=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0 || (obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL flush_after_%0d: got v=%b, exp v=0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            set_rand_instr();
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        mq.delete();
        tests++;
        if ({out_valid, in_ready, Operation, SrcA, SrcB, Illegal} !== {1'b0, 1'b1, 4'h0, 64'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_async: got v=%b r=%b op=%h a=%h b=%h ill=%b, exp v=0 r=1 op=0 a=0 b=0 ill=0",
                     out_valid, in_ready, Operation, SrcA, SrcB, Illegal);
        end
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        tests++;
        if ((obs_vec() & exp_mask()) !== exp_vec()) begin
            fails++;
            $display("FAIL reset_release: got %h exp %h", obs_vec() & exp_mask(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            set_rand_instr();
            tick();
            tests++;
            if ((obs_vec() & exp_mask()) !== exp_vec()) begin
                fails++;
                $display("FAIL random_%0d: got %h exp %h", i, obs_vec() & exp_mask(), exp_vec());
            end
        end
        flush = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_back_pressure();
        test_streaming();
        test_flush();
        test_reset_in_two();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
